conv_dispatch_scheduler: RTL
============================

CONV_DISPATCH_SCHEDULER -- requirements
Module: conv_dispatch_scheduler

Interface
REQ-001 Parameter WIDTH, default 53, SHALL set the NoC packet width: 13 + 5*FILTER_WIDTH with FILTER_WIDTH = 8.
REQ-002 Parameter PE_MASK, default 16'b1110_1111_1111_0111, SHALL mark the 14 PE-bearing nodes; nodes 3 (output port) and 12 (control) are excluded.
REQ-003 Parameter TIMESTEPS, default 10, SHALL set the number of timesteps per layer; legal range 1..15.
REQ-004 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port start_i, input, 1: layer start request; sampled only in IDLE.
REQ-007 Port abort_i, input, 1: synchronous abort.
REQ-008 Port mem_rd_o, output, 1: buffer read strobe.
REQ-009 Port mem_addr_o, output, 8: buffer read address.
REQ-010 Port mem_rdata_i, input, WIDTH-6: read data, valid exactly 1 cycle after mem_rd_o.
REQ-011 Port pkt_valid_o, output, 1: packet valid toward the router PE-side input.
REQ-012 Port pkt_ready_i, input, 1: router accepts the packet.
REQ-013 Port pkt_o, output, WIDTH: {type[1:0], dest[3:0], payload[WIDTH-7:0]}, where type 01 = filter and 10 = ifmap.
REQ-014 Port ack_valid_i, input, 1: PE completion ack; always accepted, with no ready signal.
REQ-015 Port ack_node_i, input, 4: node number of the acking PE.
REQ-016 Port busy_o, done_o, err_o, outputs, 1 each: status signals.
REQ-017 Port timestep_o, output, 4: index of the current timestep.

Function
REQ-018 The FSM states SHALL be IDLE, RD, SEND, WAIT_ACK, and NEXT.
REQ-019 IDLE with start_i=1 SHALL set busy_o=1, timestep_o=0, and node index = lowest set bit of PE_MASK (0), then go to RD.
REQ-020 RD SHALL assert mem_rd_o for exactly 1 cycle, then go to SEND.
  - Filter-phase address: {4'hF, node}.
  - Ifmap-phase address: {timestep_o, node}.
REQ-021 SEND SHALL register mem_rdata_i into the payload on entry and assert pkt_valid_o.
  - pkt_o SHALL hold stable while pkt_valid_o=1 and pkt_ready_i=0.
  - Transfer occurs on the cycle where pkt_valid_o=1 and pkt_ready_i=1.
REQ-022 Issue order per timestep:
  - Timestep 0 only: filter packets first, to every enabled node in ascending order.
  - Every timestep: then ifmap packets, to every enabled node in ascending order.
  - Nodes with a PE_MASK bit of 0 SHALL be skipped with zero cycles spent.
REQ-023 Throughput: with pkt_ready_i held 1, one packet SHALL transfer every 2 cycles (RD, SEND alternating).
REQ-024 The pending[15:0] register SHALL load PE_MASK on the cycle the first ifmap RD of a timestep is entered.
  - Acks received during issue SHALL also clear pending bits.
REQ-025 When an ack arrives on the same cycle as the pending load, pending SHALL become PE_MASK with bit ack_node_i cleared.
REQ-026 An ack whose node bit is not pending SHALL set err_o, which is sticky and is cleared only by rst or an accepted start_i.
  - This covers duplicates, disabled nodes, and acks arriving in IDLE.
  - Such an ack SHALL NOT otherwise change state.
REQ-027 WAIT_ACK SHALL be entered after the last ifmap transfer of a timestep.
  - It SHALL exit to NEXT on the first cycle where pending == 0.
  - If pending is already 0, it SHALL exit on the next cycle.
REQ-028 NEXT behaviour at the end of a timestep:
  - If timestep_o < TIMESTEPS-1: increment timestep_o and go to RD (ifmap phase, first enabled node).
  - Otherwise: pulse done_o for exactly 1 cycle, clear busy_o, and go to IDLE.
  - timestep_o SHALL hold its final value in IDLE.
REQ-029 start_i while busy_o=1 SHALL be ignored.
REQ-030 abort_i=1 in any state SHALL force IDLE on the next edge.
  - It SHALL clear pkt_valid_o, mem_rd_o, busy_o, and pending.
  - done_o SHALL NOT pulse.
  - Dropping pkt_valid_o mid-handshake is permitted only on abort.
REQ-031 abort_i SHALL take priority over start_i and acks; rst SHALL take priority over everything.

Reset
REQ-032 rst=1 at a clock edge SHALL force IDLE, from any state including mid-handshake.
  - Reset values: pkt_valid_o=0, mem_rd_o=0, mem_addr_o=0, pkt_o=0, busy_o=0, done_o=0, err_o=0, timestep_o=0, pending=0.

Verification
REQ-033 TIMESTEPS=2, pkt_ready_i=1, each PE acks 5 cycles after its ifmap packet -> 42 packets total.
  - Order: 14 filters (dest 0,1,2,4..11,13,14,15), then 14 ifmaps for t=0, then 14 ifmaps for t=1.
  - done_o SHALL pulse once; err_o SHALL remain 0.
REQ-034 pkt_ready_i low for 7 cycles during the 3rd packet -> pkt_o SHALL be stable throughout; no packet is lost or duplicated.
  - mem_rd_o SHALL pulse exactly once for that packet.
REQ-035 Node 9 acks twice within one timestep -> err_o=1 from the 2nd ack onward; the sequence SHALL still complete with done_o=1.
REQ-036 Ack for node 0 on the same cycle as the pending load -> pending SHALL equal 16'hEFF6 one cycle later.
REQ-037 abort_i asserted during WAIT_ACK of t=1 -> IDLE next cycle with busy_o=0 and no done_o pulse.
  - A new start_i SHALL then restart at timestep 0 with the filter phase.
REQ-038 rst asserted mid-SEND with pkt_valid_o=1 -> all outputs equal their REQ-032 values on the next cycle.

Source files
------------

// File: rtl/conv_dispatch_scheduler.sv
// Convolution layer dispatcher. It reads filter and ifmap words from a local
// buffer, wraps each word in a NoC packet for one PE, and tracks PE
// completion acks between timesteps.
//
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   S_IDLE     | waiting for start_i; timestep_o holds its last value
//   S_RD       | one-cycle buffer read for the current node/phase
//   S_SEND     | packet presented to the router until pkt_ready_i
//   S_WAIT_ACK | all ifmaps of the timestep issued; waiting for pending == 0
//   S_NEXT     | advance the timestep, or finish the layer
module conv_dispatch_scheduler #(
  parameter int          WIDTH     = 53,
  parameter logic [15:0] PE_MASK   = 16'b1110_1111_1111_0111,
  parameter int          TIMESTEPS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             abort_i,
  output logic             mem_rd_o,
  output logic [7:0]       mem_addr_o,
  input  logic [WIDTH-7:0] mem_rdata_i,
  output logic             pkt_valid_o,
  input  logic             pkt_ready_i,
  output logic [WIDTH-1:0] pkt_o,
  input  logic             ack_valid_i,
  input  logic [3:0]       ack_node_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [3:0]       timestep_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD       = 3'd1,
    S_SEND     = 3'd2,
    S_WAIT_ACK = 3'd3,
    S_NEXT     = 3'd4
  } state_t;

  localparam logic [3:0] LAST_TS = 4'(TIMESTEPS - 1);

  // Lowest enabled node: where every phase starts.
  function automatic logic [3:0] f_first_node();
    logic [3:0] res;
    res = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (PE_MASK[i]) res = 4'(i);
    end
    return res;
  endfunction

  // Next enabled node strictly above cur; disabled nodes are jumped over.
  function automatic logic [3:0] f_next_node(input logic [3:0] cur);
    logic [3:0] res;
    res = cur;
    for (int i = 15; i >= 0; i--) begin
      if (PE_MASK[i] && (i > int'(cur))) res = 4'(i);
    end
    return res;
  endfunction

  function automatic logic f_has_next(input logic [3:0] cur);
    logic res;
    res = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (PE_MASK[i] && (i > int'(cur))) res = 1'b1;
    end
    return res;
  endfunction

  localparam logic [3:0] FIRST_NODE = f_first_node();

  state_t           r_state;
  logic [3:0]       r_node;
  logic             r_filter;
  logic [3:0]       r_timestep;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic [15:0]      r_pending;
  logic             r_send_first;
  logic [WIDTH-1:0] r_pkt;

  state_t           w_state_nxt;
  logic [3:0]       w_node_nxt;
  logic             w_filter_nxt;
  logic [3:0]       w_ts_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_load_pend;
  logic             w_start_acc;
  logic             w_has_next;
  logic [3:0]       w_next_node;
  logic [15:0]      w_pend_base;
  logic [15:0]      w_pend_nxt;
  logic             w_ack_hit;
  logic             w_err_set;
  logic [WIDTH-1:0] w_pkt_live;

  assign w_has_next  = f_has_next(r_node);
  assign w_next_node = f_next_node(r_node);

  // Next-state and sequencing decisions; abort overrides everything but rst.
  always_comb begin
    w_state_nxt  = r_state;
    w_node_nxt   = r_node;
    w_filter_nxt = r_filter;
    w_ts_nxt     = r_timestep;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_load_pend  = 1'b0;
    w_start_acc  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_start_acc  = 1'b1;
          w_state_nxt  = S_RD;
          w_node_nxt   = FIRST_NODE;
          w_filter_nxt = 1'b1;
          w_ts_nxt     = 4'd0;
          w_busy_nxt   = 1'b1;
        end
      end
      S_RD: w_state_nxt = S_SEND;
      S_SEND: begin
        if (pkt_ready_i) begin
          if (w_has_next) begin
            w_node_nxt  = w_next_node;
            w_state_nxt = S_RD;
          end else if (r_filter) begin
            // filters done: the first ifmap read of timestep 0 arms pending
            w_filter_nxt = 1'b0;
            w_node_nxt   = FIRST_NODE;
            w_state_nxt  = S_RD;
            w_load_pend  = 1'b1;
          end else begin
            w_state_nxt = S_WAIT_ACK;
          end
        end
      end
      S_WAIT_ACK: begin
        if (r_pending == 16'd0) w_state_nxt = S_NEXT;
      end
      S_NEXT: begin
        if (r_timestep < LAST_TS) begin
          w_ts_nxt     = r_timestep + 4'd1;
          w_node_nxt   = FIRST_NODE;
          w_filter_nxt = 1'b0;
          w_state_nxt  = S_RD;
          w_load_pend  = 1'b1;
        end else begin
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (abort_i) begin
      w_state_nxt = S_IDLE;
      w_busy_nxt  = 1'b0;
      w_done_nxt  = 1'b0;
      w_load_pend = 1'b0;
      w_start_acc = 1'b0;
    end
  end

  // Ack bookkeeping: an ack landing on the load cycle is applied to the
  // freshly loaded mask, so it clears its bit instead of flagging an error.
  always_comb begin
    w_pend_base = w_load_pend ? PE_MASK : r_pending;
    w_ack_hit   = ack_valid_i && w_pend_base[ack_node_i];
    w_err_set   = ack_valid_i && !abort_i && !w_pend_base[ack_node_i];
    w_pend_nxt  = w_pend_base;
    if (w_ack_hit) w_pend_nxt = w_pend_base & ~(16'd1 << ack_node_i);
    if (abort_i) w_pend_nxt = 16'd0;
  end

  // Buffer data arrives in the first SEND cycle; it is shown directly then and
  // held in r_pkt for the rest of a stalled handshake.
  assign w_pkt_live = {(r_filter ? 2'b01 : 2'b10), r_node, mem_rdata_i};

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_node       <= 4'd0;
      r_filter     <= 1'b0;
      r_timestep   <= 4'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_pending    <= 16'd0;
      r_send_first <= 1'b0;
      r_pkt        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_node       <= w_node_nxt;
      r_filter     <= w_filter_nxt;
      r_timestep   <= w_ts_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_pending    <= w_pend_nxt;
      r_send_first <= (r_state == S_RD) && (w_state_nxt == S_SEND);
      if (r_send_first) r_pkt <= w_pkt_live;
      if (w_err_set) r_err <= 1'b1;
      else if (w_start_acc) r_err <= 1'b0;
    end
  end

  assign mem_rd_o    = (r_state == S_RD);
  assign mem_addr_o  = !mem_rd_o ? 8'h00 :
                       (r_filter ? {4'hF, r_node} : {r_timestep, r_node});
  assign pkt_valid_o = (r_state == S_SEND);
  assign pkt_o       = r_send_first ? w_pkt_live : r_pkt;
  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign err_o       = r_err;
  assign timestep_o  = r_timestep;

endmodule
